sata_oob_controller: RTL and testbench

Host-side SATA out-of-band (OOB) link-initialisation controller. It sequences COMRESET, COMINIT, COMWAKE, D10.2 and ALIGN through the transceiver control pins. It asserts linkup once the device is primitive-aligned. It sits inside the SATA PHY layer, which muxes this block's tx_dout/tx_is_k onto the transceiver while linkup is low.

---
 rtl/sata_oob_controller.sv | 207 ++++++++++++++++++++
 tb/tb_sata_oob_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_oob_controller.sv
// ---------------------------------------------------------------------------
// sata_oob_controller
//
// Host-side SATA out-of-band link bring-up sequencer. Walks the transceiver
// through COMRESET, COMINIT, COMWAKE, the D10.2 dial tone and ALIGN exchange,
// then raises linkup once the device has sent a non-ALIGN K primitive after
// ALIGN lock. While linkup is low the surrounding PHY layer puts tx_dout and
// tx_is_k on the wire.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   phy_error         decode/disparity error on the current rx word
//   platform_ready    transceiver PLL/reset done
//   platform_error    platform_ready was lost while outside IDLE
//   linkup            link established
//   tx_dout           transmit word
//   tx_is_k           tx_dout byte 0 is a K character
//   tx_comm_reset     request a COMRESET burst
//   tx_comm_wake      request a COMWAKE burst
//   tx_set_elec_idle  force the transmitter into electrical idle
//   tx_oob_complete   requested OOB burst finished
//   rx_din            received word
//   rx_is_k           per-byte K flags of rx_din
//   comm_init_detect  COMINIT detected
//   comm_wake_detect  COMWAKE detected
//   rx_is_elec_idle   receiver sees electrical idle
//   lax_state         current state code (debug)
// ---------------------------------------------------------------------------
module sata_oob_controller #(
  parameter logic [31:0] INIT_TIMEOUT  = 32'd100000,
  parameter logic [31:0] ALIGN_TIMEOUT = 32'd100000,
  parameter logic [31:0] PRIM_ALIGN    = 32'h7B4A4ABC,
  parameter logic [31:0] DIAL_TONE     = 32'h4A4A4A4A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_error,
  input  logic        platform_ready,
  output logic        platform_error,
  output logic        linkup,
  output logic [31:0] tx_dout,
  output logic        tx_is_k,
  output logic        tx_comm_reset,
  output logic        tx_comm_wake,
  output logic        tx_set_elec_idle,
  input  logic        tx_oob_complete,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_is_k,
  input  logic        comm_init_detect,
  input  logic        comm_wake_detect,
  input  logic        rx_is_elec_idle,
  output logic [3:0]  lax_state
);

  typedef enum logic [3:0] {
    IDLE             = 4'd0,
    SEND_RESET       = 4'd1,
    WAIT_FOR_INIT    = 4'd2,
    WAIT_FOR_NO_INIT = 4'd3,
    SEND_WAKE        = 4'd4,
    WAIT_FOR_WAKE    = 4'd5,
    WAIT_FOR_NO_WAKE = 4'd6,
    WAIT_FOR_IDLE    = 4'd7,
    SEND_ALIGN       = 4'd8,
    DETECT_SYNC      = 4'd9,
    READY            = 4'd10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] timer;
  logic        rx_valid;
  logic        align_det;
  logic        sync_det;
  logic        platform_lost;
  logic        unused_rx_k;

  // Only byte 0 carries the K character of a primitive; the upper K flags
  // carry no information for link bring-up.
  assign unused_rx_k = ^rx_is_k[3:1];

  // Any word flagged with a decode error is treated as if nothing arrived,
  // so neither ALIGN lock nor the sync primitive can be faked by line noise.
  assign rx_valid  = ~phy_error;
  assign align_det = rx_valid & rx_is_k[0] & (rx_din == PRIM_ALIGN);
  assign sync_det  = rx_valid & rx_is_k[0] & (rx_din != PRIM_ALIGN);

  // Losing the transceiver only matters once we have left IDLE.
  assign platform_lost = (state != IDLE) & ~platform_ready;

  assign lax_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timer restarts whenever the state changes so each timeout is measured
  // from state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // Sticky platform error: set when the transceiver drops out mid bring-up
  // or while linked, cleared only once it is back and we are in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      platform_error <= 1'b0;
    end else if (platform_lost) begin
      platform_error <= 1'b1;
    end else if ((state == IDLE) && platform_ready) begin
      platform_error <= 1'b0;
    end
  end

  // Next-state logic. Timeouts are tested after the normal transition so
  // they win, and platform loss is applied last so it beats everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (platform_ready) state_next = SEND_RESET;
      end
      SEND_RESET: begin
        if (tx_oob_complete) state_next = WAIT_FOR_INIT;
      end
      WAIT_FOR_INIT: begin
        if (comm_init_detect) state_next = WAIT_FOR_NO_INIT;
        if (timer == INIT_TIMEOUT) state_next = SEND_RESET;
      end
      WAIT_FOR_NO_INIT: begin
        if (!comm_init_detect) state_next = SEND_WAKE;
      end
      SEND_WAKE: begin
        if (tx_oob_complete) state_next = WAIT_FOR_WAKE;
      end
      WAIT_FOR_WAKE: begin
        if (comm_wake_detect) state_next = WAIT_FOR_NO_WAKE;
        if (timer == INIT_TIMEOUT) state_next = SEND_WAKE;
      end
      WAIT_FOR_NO_WAKE: begin
        if (!comm_wake_detect) state_next = WAIT_FOR_IDLE;
      end
      WAIT_FOR_IDLE: begin
        if (!rx_is_elec_idle) state_next = SEND_ALIGN;
      end
      SEND_ALIGN: begin
        if (align_det) state_next = DETECT_SYNC;
        if (timer == ALIGN_TIMEOUT) state_next = SEND_RESET;
      end
      DETECT_SYNC: begin
        if (sync_det) state_next = READY;
      end
      READY: begin
        if (rx_is_elec_idle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (platform_lost) state_next = IDLE;
  end

  // Outputs are a pure decode of the current state, so any exit to IDLE
  // (reset, platform loss, device going idle) drops every request and
  // linkup on the same cycle the state changes.
  always_comb begin
    linkup           = 1'b0;
    tx_dout          = 32'd0;
    tx_is_k          = 1'b0;
    tx_comm_reset    = 1'b0;
    tx_comm_wake     = 1'b0;
    tx_set_elec_idle = 1'b1;
    case (state)
      SEND_RESET: tx_comm_reset = 1'b1;
      SEND_WAKE:  tx_comm_wake  = 1'b1;
      SEND_ALIGN: begin
        tx_set_elec_idle = 1'b0;
        tx_dout          = DIAL_TONE;
      end
      DETECT_SYNC: begin
        tx_set_elec_idle = 1'b0;
        tx_dout          = PRIM_ALIGN;
        tx_is_k          = 1'b1;
      end
      READY: begin
        tx_set_elec_idle = 1'b0;
        tx_dout          = PRIM_ALIGN;
        tx_is_k          = 1'b1;
        linkup           = 1'b1;
      end
      default: begin
        tx_set_elec_idle = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sata_oob_controller.sv
// ---------------------------------------------------------------------------
// tb_sata_oob_controller
//
// Directed testbench for sata_oob_controller with both timeouts shortened to
// 100 clocks. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_sata_oob_controller;

  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
  localparam logic [31:0] DIAL_W  = 32'h4A4A4A4A;
  localparam logic [31:0] SYNC_W  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        rst;
  logic        phy_error;
  logic        platform_ready;
  logic        platform_error;
  logic        linkup;
  logic [31:0] tx_dout;
  logic        tx_is_k;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic        tx_set_elec_idle;
  logic        tx_oob_complete;
  logic [31:0] rx_din;
  logic [3:0]  rx_is_k;
  logic        comm_init_detect;
  logic        comm_wake_detect;
  logic        rx_is_elec_idle;
  logic [3:0]  lax_state;

  int tests_run    = 0;
  int tests_failed = 0;

  sata_oob_controller #(
    .INIT_TIMEOUT (32'd100),
    .ALIGN_TIMEOUT(32'd100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .phy_error       (phy_error),
    .platform_ready  (platform_ready),
    .platform_error  (platform_error),
    .linkup          (linkup),
    .tx_dout         (tx_dout),
    .tx_is_k         (tx_is_k),
    .tx_comm_reset   (tx_comm_reset),
    .tx_comm_wake    (tx_comm_wake),
    .tx_set_elec_idle(tx_set_elec_idle),
    .tx_oob_complete (tx_oob_complete),
    .rx_din          (rx_din),
    .rx_is_k         (rx_is_k),
    .comm_init_detect(comm_init_detect),
    .comm_wake_detect(comm_wake_detect),
    .rx_is_elec_idle (rx_is_elec_idle),
    .lax_state       (lax_state)
  );

  always #5 clk = ~clk;

  // One clock, then settle past the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with all inputs quiet, then walk the handshake up to the target
  // state code without looking at the DUT.
  task automatic drive_to_state(input int target);
    rst = 1'b1; phy_error = 1'b0; platform_ready = 1'b0;
    tx_oob_complete = 1'b0; rx_din = 32'd0; rx_is_k = 4'd0;
    comm_init_detect = 1'b0; comm_wake_detect = 1'b0; rx_is_elec_idle = 1'b1;
    tick();
    rst = 1'b0;
    if (target == 0) return;
    platform_ready = 1'b1; tick();
    if (target == 1) return;
    tx_oob_complete = 1'b1; tick(); tx_oob_complete = 1'b0;
    if (target == 2) return;
    comm_init_detect = 1'b1; tick();
    if (target == 3) return;
    comm_init_detect = 1'b0; tick();
    if (target == 4) return;
    tx_oob_complete = 1'b1; tick(); tx_oob_complete = 1'b0;
    if (target == 5) return;
    comm_wake_detect = 1'b1; tick();
    if (target == 6) return;
    comm_wake_detect = 1'b0; tick();
    if (target == 7) return;
    rx_is_elec_idle = 1'b0; tick();
    if (target == 8) return;
    rx_din = ALIGN_W; rx_is_k = 4'b0001; tick();
    if (target == 9) return;
    rx_din = SYNC_W; tick();
  endtask

  // Reset values, and platform_ready low in IDLE must not raise an error.
  task automatic test_reset();
    drive_to_state(0);
    tests_run++;
    if (lax_state !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", lax_state); end
    tests_run++;
    if ({linkup, platform_error, tx_comm_reset, tx_comm_wake, tx_set_elec_idle, tx_is_k} !== 6'b000010) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000010",
        {linkup, platform_error, tx_comm_reset, tx_comm_wake, tx_set_elec_idle, tx_is_k});
    end
    tests_run++;
    if (tx_dout !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h expected 00000000", tx_dout); end
    tick(3);
    tests_run++;
    if ({lax_state, platform_error} !== {4'd0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL idle_no_ready: got state %0d err %b expected state 0 err 0", lax_state, platform_error);
    end
  endtask

  // Full clean handshake with OOB completions 5 cycles after each request.
  task automatic test_bringup();
    drive_to_state(0);
    platform_ready = 1'b1; tick();
    tests_run++;
    if ({lax_state, tx_comm_reset, tx_set_elec_idle} !== {4'd1, 1'b1, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL bu_send_reset: got state %0d rst %b idle %b expected 1 1 1", lax_state, tx_comm_reset, tx_set_elec_idle);
    end
    tick(4);
    tx_oob_complete = 1'b1; tick(); tx_oob_complete = 1'b0;
    tests_run++;
    if ({lax_state, tx_comm_reset} !== {4'd2, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bu_wait_init: got state %0d rst %b expected 2 0", lax_state, tx_comm_reset);
    end
    comm_init_detect = 1'b1; tick(3);
    tests_run++;
    if (lax_state !== 4'd3) begin tests_failed++; $display("[TB] FAIL bu_no_init: got %0d expected 3", lax_state); end
    comm_init_detect = 1'b0; tick();
    tests_run++;
    if ({lax_state, tx_comm_wake} !== {4'd4, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL bu_send_wake: got state %0d wake %b expected 4 1", lax_state, tx_comm_wake);
    end
    tick(4);
    tx_oob_complete = 1'b1; tick(); tx_oob_complete = 1'b0;
    tests_run++;
    if ({lax_state, tx_comm_wake} !== {4'd5, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bu_wait_wake: got state %0d wake %b expected 5 0", lax_state, tx_comm_wake);
    end
    comm_wake_detect = 1'b1; tick(3);
    tests_run++;
    if (lax_state !== 4'd6) begin tests_failed++; $display("[TB] FAIL bu_no_wake: got %0d expected 6", lax_state); end
    comm_wake_detect = 1'b0; tick(2);
    tests_run++;
    if ({lax_state, tx_set_elec_idle, tx_dout} !== {4'd7, 1'b1, 32'd0}) begin
      tests_failed++; $display("[TB] FAIL bu_wait_idle: got state %0d idle %b dout %h expected 7 1 00000000", lax_state, tx_set_elec_idle, tx_dout);
    end
    rx_is_elec_idle = 1'b0; tick();
    tests_run++;
    if ({lax_state, tx_set_elec_idle, tx_dout, tx_is_k} !== {4'd8, 1'b0, DIAL_W, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bu_send_align: got state %0d idle %b dout %h k %b expected 8 0 %h 0", lax_state, tx_set_elec_idle, tx_dout, tx_is_k, DIAL_W);
    end
    rx_din = ALIGN_W; rx_is_k = 4'b0001; tick(2);
    tests_run++;
    if ({lax_state, tx_dout, tx_is_k, linkup} !== {4'd9, ALIGN_W, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bu_detect_sync: got state %0d dout %h k %b link %b expected 9 %h 1 0", lax_state, tx_dout, tx_is_k, linkup, ALIGN_W);
    end
    rx_din = SYNC_W; tick();
    tests_run++;
    if ({lax_state, tx_dout, tx_is_k, linkup} !== {4'd10, ALIGN_W, 1'b1, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL bu_ready: got state %0d dout %h k %b link %b expected 10 %h 1 1", lax_state, tx_dout, tx_is_k, linkup, ALIGN_W);
    end
    phy_error = 1'b1; rx_din = 32'hDEADBEEF; tick(2); phy_error = 1'b0;
    tests_run++;
    if ({lax_state, linkup} !== {4'd10, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL bu_phy_err_ready: got state %0d link %b expected 10 1", lax_state, linkup);
    end
    rx_is_elec_idle = 1'b1; tick();
    tests_run++;
    if ({lax_state, linkup, platform_error} !== {4'd0, 1'b0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bu_device_idle: got state %0d link %b err %b expected 0 0 0", lax_state, linkup, platform_error);
    end
  endtask

  // Timer clears on entry to WAIT_FOR_INIT and the exit fires in the cycle
  // where it reads 100, so state 2 is held across 100 edges and left on the 101st.
  task automatic test_init_timeout();
    drive_to_state(2);
    tick(100);
    tests_run++;
    if (lax_state !== 4'd2) begin tests_failed++; $display("[TB] FAIL init_to_hold: got %0d expected 2", lax_state); end
    tick();
    tests_run++;
    if ({lax_state, tx_comm_reset} !== {4'd1, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL init_to_retry: got state %0d rst %b expected 1 1", lax_state, tx_comm_reset);
    end
  endtask

  // No ALIGN from the device: back to COMRESET with the transmitter idle.
  task automatic test_align_timeout();
    drive_to_state(8);
    tick(100);
    tests_run++;
    if (lax_state !== 4'd8) begin tests_failed++; $display("[TB] FAIL align_to_hold: got %0d expected 8", lax_state); end
    tick();
    tests_run++;
    if ({lax_state, tx_set_elec_idle, tx_dout, tx_comm_reset} !== {4'd1, 1'b1, 32'd0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL align_to_retry: got state %0d idle %b dout %h rst %b expected 1 1 00000000 1", lax_state, tx_set_elec_idle, tx_dout, tx_comm_reset);
    end
  endtask

  // ALIGN carrying a decode error must not advance; a clean one must.
  task automatic test_corrupted_align();
    drive_to_state(8);
    rx_din = ALIGN_W; rx_is_k = 4'b0001; phy_error = 1'b1; tick(3);
    tests_run++;
    if ({lax_state, tx_dout, tx_is_k} !== {4'd8, DIAL_W, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bad_align_hold: got state %0d dout %h k %b expected 8 %h 0", lax_state, tx_dout, tx_is_k, DIAL_W);
    end
    rx_is_k = 4'b0000; phy_error = 1'b0; tick();
    tests_run++;
    if (lax_state !== 4'd8) begin tests_failed++; $display("[TB] FAIL align_no_k: got %0d expected 8", lax_state); end
    rx_is_k = 4'b0001; tick();
    tests_run++;
    if (lax_state !== 4'd9) begin tests_failed++; $display("[TB] FAIL good_align: got %0d expected 9", lax_state); end
    phy_error = 1'b1; rx_din = SYNC_W; tick();
    tests_run++;
    if (lax_state !== 4'd9) begin tests_failed++; $display("[TB] FAIL bad_sync_hold: got %0d expected 9", lax_state); end
    phy_error = 1'b0;
  endtask

  // Platform loss while linked, then recovery.
  task automatic test_platform_loss();
    drive_to_state(10);
    platform_ready = 1'b0; tick();
    tests_run++;
    if ({lax_state, linkup, platform_error, tx_set_elec_idle} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL ploss_drop: got state %0d link %b err %b idle %b expected 0 0 1 1", lax_state, linkup, platform_error, tx_set_elec_idle);
    end
    tick(2);
    tests_run++;
    if ({lax_state, platform_error} !== {4'd0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL ploss_sticky: got state %0d err %b expected 0 1", lax_state, platform_error);
    end
    platform_ready = 1'b1; tick();
    tests_run++;
    if ({lax_state, platform_error} !== {4'd1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL ploss_recover: got state %0d err %b expected 1 0", lax_state, platform_error);
    end
  endtask

  // Reset while waiting for COMWAKE wins over everything.
  task automatic test_reset_midop();
    drive_to_state(5);
    comm_wake_detect = 1'b1; rst = 1'b1; tick();
    tests_run++;
    if ({lax_state, linkup, platform_error, tx_comm_reset, tx_comm_wake, tx_set_elec_idle, tx_is_k, tx_dout}
        !== {4'd0, 6'b000010, 32'd0}) begin
      tests_failed++; $display("[TB] FAIL midop_reset: got state %0d flags %b dout %h expected 0 000010 00000000",
        lax_state, {linkup, platform_error, tx_comm_reset, tx_comm_wake, tx_set_elec_idle, tx_is_k}, tx_dout);
    end
    rst = 1'b0; comm_wake_detect = 1'b0;
  endtask

  // Back-to-back link bring-ups through a device-idle drop.
  task automatic test_back_to_back();
    drive_to_state(10);
    rx_is_elec_idle = 1'b1; tick();
    rx_is_elec_idle = 1'b0; tick();
    tests_run++;
    if (lax_state !== 4'd1) begin tests_failed++; $display("[TB] FAIL b2b_restart: got %0d expected 1", lax_state); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_init_timeout();
    test_align_timeout();
    test_corrupted_align();
    test_platform_loss();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
